// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope generator.
// Holds the phase encoding, sustain clamp limits, default step sizes and the target helper.
package adsr_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } adsr_state_e;

  localparam logic [2:0] ST_IDLE    = S_IDLE;
  localparam logic [2:0] ST_ATTACK  = S_ATTACK;
  localparam logic [2:0] ST_DECAY   = S_DECAY;
  localparam logic [2:0] ST_SUSTAIN = S_SUSTAIN;
  localparam logic [2:0] ST_RELEASE = S_RELEASE;

  localparam logic [3:0] SUS_MIN = 4'd2;
  localparam logic [3:0] SUS_MAX = 4'd12;

  localparam int ATK_STEP_DEF = 8;
  localparam int DEC_STEP_DEF = 4;
  localparam int REL_STEP_DEF = 4;

  // Sustain level code clamped to SUS_MIN..SUS_MAX, scaled by 16.
  function automatic logic [7:0] sus_target(input logic [3:0] lvl);
    logic [3:0] c;
    if (lvl < SUS_MIN)      c = SUS_MIN;
    else if (lvl > SUS_MAX) c = SUS_MAX;
    else                    c = lvl;
    return {c, 4'b0000};
  endfunction

endpackage

// File: rtl/adsr_envelope_rise_fall_detect.sv
// Registered edge detector: one-cycle rise/fall pulses one clock after the input edge.
// Latency 1 cycle, no backpressure; history and pulses clear on reset.
module rise_fall_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
      fall_q <= ~sig_i & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope: 8-bit amplitude driven by gate edges and per-phase tick events.
// Latency: edges act two clocks after the input changes; outputs registered, no backpressure.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int ATK_STEP = ATK_STEP_DEF,
  parameter int DEC_STEP = DEC_STEP_DEF,
  parameter int REL_STEP = REL_STEP_DEF
) (
  input  logic       clk50Mhz,
  input  logic       Reset,
  input  logic       GATE,
  input  logic       TICK_A,
  input  logic       TICK_D,
  input  logic       TICK_R,
  input  logic [3:0] SUS_LVL,
  output logic [7:0] ENV,
  output logic [2:0] STATE,
  output logic       ACTIVE
);

  localparam logic [8:0] ATK9 = 9'(ATK_STEP);
  localparam logic [8:0] DEC9 = 9'(DEC_STEP);
  localparam logic [8:0] REL9 = 9'(REL_STEP);

  logic gate_rise, gate_fall;
  logic tick_a, tick_d, tick_r;
  logic tick_a_fall_unused, tick_d_fall_unused, tick_r_fall_unused;

  rise_fall_detect u_gate_det (
    .clk_i(clk50Mhz), .rst_n_i(Reset), .sig_i(GATE),
    .rise_o(gate_rise), .fall_o(gate_fall)
  );
  rise_fall_detect u_tick_a_det (
    .clk_i(clk50Mhz), .rst_n_i(Reset), .sig_i(TICK_A),
    .rise_o(tick_a), .fall_o(tick_a_fall_unused)
  );
  rise_fall_detect u_tick_d_det (
    .clk_i(clk50Mhz), .rst_n_i(Reset), .sig_i(TICK_D),
    .rise_o(tick_d), .fall_o(tick_d_fall_unused)
  );
  rise_fall_detect u_tick_r_det (
    .clk_i(clk50Mhz), .rst_n_i(Reset), .sig_i(TICK_R),
    .rise_o(tick_r), .fall_o(tick_r_fall_unused)
  );

  logic [2:0] state_q, state_d;
  logic [7:0] env_q, env_d;
  logic [7:0] tgt;

  assign tgt = sus_target(SUS_LVL);

  always_comb begin
    logic [8:0] env9;
    logic [8:0] tgt9;
    logic [8:0] sum9;
    env9    = {1'b0, env_q};
    tgt9    = {1'b0, tgt};
    sum9    = env9 + ATK9;
    state_d = state_q;
    env_d   = env_q;

    if (state_q > ST_RELEASE) begin
      state_d = ST_IDLE;
      env_d   = 8'd0;
    end else if (gate_rise) begin
      // Legato retrigger: keep the current amplitude, any tick this cycle is dropped.
      state_d = ST_ATTACK;
    end else if (gate_fall) begin
      if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN) begin
        state_d = ST_RELEASE;
      end
    end else begin
      case (state_q)
        ST_ATTACK: begin
          if (tick_a) begin
            if (sum9 >= 9'd255) begin
              env_d   = 8'd255;
              state_d = ST_DECAY;
            end else begin
              env_d = sum9[7:0];
            end
          end
        end
        ST_DECAY: begin
          if (tick_d) begin
            if (env9 <= tgt9 + DEC9) begin
              env_d   = tgt;
              state_d = ST_SUSTAIN;
            end else begin
              env_d = env_q - DEC9[7:0];
            end
          end
        end
        ST_SUSTAIN: env_d = tgt;
        ST_RELEASE: begin
          if (tick_r) begin
            if (env9 <= REL9) begin
              env_d   = 8'd0;
              state_d = ST_IDLE;
            end else begin
              env_d = env_q - REL9[7:0];
            end
          end
        end
        default: env_d = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk50Mhz or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      env_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  assign ENV    = env_q;
  assign STATE  = state_q;
  assign ACTIVE = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: walks attack, decay, sustain clamp, release, retrigger and reset.
// Inputs change on the falling clock edge and outputs are sampled there too.
module tb_adsr_envelope;

  logic       clk50Mhz;
  logic       Reset;
  logic       GATE;
  logic       TICK_A;
  logic       TICK_D;
  logic       TICK_R;
  logic [3:0] SUS_LVL;
  logic [7:0] ENV;
  logic [2:0] STATE;
  logic       ACTIVE;

  int vectors;
  int miscompares;

  adsr_envelope dut (
    .clk50Mhz(clk50Mhz),
    .Reset(Reset),
    .GATE(GATE),
    .TICK_A(TICK_A),
    .TICK_D(TICK_D),
    .TICK_R(TICK_R),
    .SUS_LVL(SUS_LVL),
    .ENV(ENV),
    .STATE(STATE),
    .ACTIVE(ACTIVE)
  );

  initial clk50Mhz = 1'b0;
  always #10 clk50Mhz = ~clk50Mhz;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // which: 0=TICK_A 1=TICK_D 2=TICK_R; returns after the envelope register has updated.
  task automatic pulse(input int which);
    case (which)
      0: TICK_A = 1'b1;
      1: TICK_D = 1'b1;
      default: TICK_R = 1'b1;
    endcase
    @(negedge clk50Mhz);
    TICK_A = 1'b0;
    TICK_D = 1'b0;
    TICK_R = 1'b0;
    @(negedge clk50Mhz);
  endtask

  task automatic set_gate(input logic g);
    GATE = g;
    repeat (2) @(negedge clk50Mhz);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset   = 1'b0;
    GATE    = 1'b1;
    TICK_A  = 1'b0;
    TICK_D  = 1'b0;
    TICK_R  = 1'b0;
    SUS_LVL = 4'd6;
    repeat (2) @(negedge clk50Mhz);
    chk("rst_env", ENV, 0);
    chk("rst_state", STATE, 0);
    chk("rst_active", ACTIVE, 0);

    // GATE already high at reset release: gate-on seen on the 1st clock, ATTACK on the 2nd.
    Reset = 1'b1;
    @(negedge clk50Mhz);
    chk("gate_lat1_state", STATE, 0);
    @(negedge clk50Mhz);
    chk("gate_lat2_state", STATE, 1);
    chk("gate_lat2_active", ACTIVE, 1);
    chk("gate_lat2_env", ENV, 0);

    for (int i = 1; i <= 32; i++) begin
      pulse(0);
      chk($sformatf("atk_env_%0d", i), ENV, (i * 8 > 255) ? 255 : i * 8);
      if (i == 5) begin
        pulse(1);
        chk("atk_ignore_d", ENV, 40);
      end
    end
    chk("atk_to_decay", STATE, 2);

    for (int i = 1; i <= 39; i++) begin
      pulse(1);
      chk($sformatf("dec_env_%0d", i), ENV, 255 - 4 * i);
      if (i == 10) begin
        pulse(0);
        chk("dec_ignore_a", ENV, 215);
      end
    end
    chk("dec_39_state", STATE, 2);
    pulse(1);
    chk("dec_40_env", ENV, 96);
    chk("dec_40_state", STATE, 3);

    SUS_LVL = 4'd15;
    @(negedge clk50Mhz);
    chk("sus_clamp_hi", ENV, 192);
    SUS_LVL = 4'd0;
    @(negedge clk50Mhz);
    chk("sus_clamp_lo", ENV, 32);
    SUS_LVL = 4'd6;
    @(negedge clk50Mhz);
    chk("sus_back", ENV, 96);
    pulse(2);
    chk("sus_ignore_r", ENV, 96);
    chk("sus_state", STATE, 3);

    set_gate(1'b0);
    chk("rel_state", STATE, 4);
    chk("rel_env", ENV, 96);
    for (int i = 1; i <= 24; i++) begin
      pulse(2);
      chk($sformatf("rel_env_%0d", i), ENV, 96 - 4 * i);
    end
    chk("rel_idle_state", STATE, 0);
    chk("rel_idle_active", ACTIVE, 0);
    pulse(2);
    chk("idle_ignore_r", ENV, 0);

    set_gate(1'b1);
    for (int i = 0; i < 6; i++) pulse(0);
    chk("re_atk_env", ENV, 48);
    set_gate(1'b0);
    pulse(2);
    pulse(2);
    chk("re_rel_env", ENV, 40);
    chk("re_rel_state", STATE, 4);
    set_gate(1'b1);
    chk("retrig_state", STATE, 1);
    chk("retrig_env", ENV, 40);
    pulse(0);
    chk("retrig_tick", ENV, 48);

    set_gate(1'b0);
    chk("coll_rel_state", STATE, 4);
    GATE   = 1'b1;
    TICK_R = 1'b1;
    @(negedge clk50Mhz);
    TICK_R = 1'b0;
    @(negedge clk50Mhz);
    chk("coll_state", STATE, 1);
    chk("coll_env", ENV, 48);

    for (int i = 0; i < 9; i++) pulse(0);
    chk("mid_atk_env", ENV, 120);
    @(negedge clk50Mhz);
    #5 Reset = 1'b0;
    #1;
    chk("async_rst_env", ENV, 0);
    chk("async_rst_state", STATE, 0);
    chk("async_rst_active", ACTIVE, 0);
    GATE   = 1'b0;
    TICK_A = 1'b1;
    @(negedge clk50Mhz);
    Reset = 1'b1;
    repeat (4) @(negedge clk50Mhz);
    chk("post_rst_env", ENV, 0);
    chk("post_rst_state", STATE, 0);
    TICK_A = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
